// File: rtl/k423_ex_mdu.sv
// k423_ex_mdu: iterative RV32M multiply/divide unit sitting in the EX stage.
//
// It is the consuming end of the ID->EX handshake. While an MDU instruction
// computes it holds ex_stage_rdy_o low so the ID/EX register keeps its
// contents. Results leave through a valid/ready pair towards MEM.
//
// Ports:
//   clk_i, rst_n_i       clock, synchronous active-low reset
//   ex_stage_vld_i       ID->EX valid
//   ex_stage_rdy_o       EX ready back to the ID/EX register (combinational)
//   pcu_flush_br_i       branch flush; aborts any op in flight, blocks accept
//   ex_mdu_sel_i         instruction in EX belongs to the MDU group
//   ex_mdu_op_i          funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   ex_dec_rs1_i/rs2_i   operands
//   ex_dec_rd_idx_i      destination register index
//   mem_stage_rdy_i      downstream ready
//   mdu_res_vld_o        result valid (DONE state)
//   mdu_res_o            result
//   mdu_rd_idx_o         destination of the result
//   mdu_busy_o           unit is not idle
module k423_ex_mdu #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_stage_vld_i,
  output logic              ex_stage_rdy_o,
  input  logic              pcu_flush_br_i,
  input  logic              ex_mdu_sel_i,
  input  logic [2:0]        ex_mdu_op_i,
  input  logic [XLEN-1:0]   ex_dec_rs1_i,
  input  logic [XLEN-1:0]   ex_dec_rs2_i,
  input  logic [RIDX_W-1:0] ex_dec_rd_idx_i,
  input  logic              mem_stage_rdy_i,
  output logic              mdu_res_vld_o,
  output logic [XLEN-1:0]   mdu_res_o,
  output logic [RIDX_W-1:0] mdu_rd_idx_o,
  output logic              mdu_busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_w(input logic [2*XLEN-1:0] x, input logic n);
    return n ? (~x + (2*XLEN)'(1)) : x;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            op_q;
  logic                  neg_q;
  // Multiplicand for multiplies, divisor for divides.
  logic [XLEN-1:0]       opd_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0]     acc_q;

  logic                  accept;
  logic                  rs1_signed, rs2_signed, a_sgn, b_sgn;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic                  div0, ovf, special;
  logic [XLEN-1:0]       spec_res;

  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_nxt;
  logic [XLEN:0]         div_shift;
  logic                  div_ge;
  logic [XLEN-1:0]       div_sub, div_rem;
  logic [2*XLEN-1:0]     div_nxt;
  logic [2*XLEN-1:0]     acc_nxt;
  logic [2*XLEN-1:0]     prod_s;
  logic [XLEN-1:0]       mul_res, div_res, fin_res;

  // Operand decode at accept
  always_comb begin
    rs1_signed = !(ex_mdu_op_i == 3'd3 || ex_mdu_op_i == 3'd5 || ex_mdu_op_i == 3'd7);
    rs2_signed = (ex_mdu_op_i == 3'd0 || ex_mdu_op_i == 3'd1 ||
                  ex_mdu_op_i == 3'd4 || ex_mdu_op_i == 3'd6);
    a_sgn      = rs1_signed & ex_dec_rs1_i[XLEN-1];
    b_sgn      = rs2_signed & ex_dec_rs2_i[XLEN-1];
    a_mag      = cneg_x(ex_dec_rs1_i, a_sgn);
    b_mag      = cneg_x(ex_dec_rs2_i, b_sgn);
    div0       = ex_mdu_op_i[2] && (ex_dec_rs2_i == '0);
    ovf        = (ex_mdu_op_i == 3'd4 || ex_mdu_op_i == 3'd6) &&
                 (ex_dec_rs1_i == INT_MIN) && (&ex_dec_rs2_i);
    special    = div0 | ovf;
    spec_res   = '0;
    if (div0)
      spec_res = ex_mdu_op_i[1] ? ex_dec_rs1_i : '1;
    else if (ovf)
      spec_res = ex_mdu_op_i[1] ? '0 : INT_MIN;
  end

  // One iteration step for each algorithm
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opd_q};
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low XLEN bits hold it exactly.
    div_sub   = div_shift[XLEN-1:0] - opd_q;
    div_rem   = div_ge ? div_sub : div_shift[XLEN-1:0];
    div_nxt   = {div_rem, acc_q[XLEN-2:0], div_ge};
    acc_nxt   = op_q[2] ? div_nxt : mul_nxt;
    prod_s    = cneg_w(mul_nxt, neg_q);
    mul_res   = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_res   = op_q[1] ? cneg_x(div_nxt[2*XLEN-1:XLEN], neg_q)
                        : cneg_x(div_nxt[XLEN-1:0], neg_q);
    fin_res   = op_q[2] ? div_res : mul_res;
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: begin
        if (pcu_flush_br_i)         state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: if (pcu_flush_br_i || mem_stage_rdy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept         = (state_q == IDLE) && ex_stage_vld_i && ex_mdu_sel_i && !pcu_flush_br_i;
    ex_stage_rdy_o = (state_q == IDLE) ||
                     ((state_q == DONE) && mem_stage_rdy_i && !pcu_flush_br_i);
    mdu_busy_o     = (state_q != IDLE);
  end

  // Control and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q         <= '0;
      mdu_res_vld_o <= 1'b0;
      mdu_res_o     <= '0;
      mdu_rd_idx_o  <= '0;
    end else begin
      mdu_res_vld_o <= (state_d == DONE);
      cnt_q         <= (state_q == CALC && state_d == CALC) ? cnt_q + CNT_W'(1) : '0;
      if (accept) begin
        mdu_rd_idx_o <= ex_dec_rd_idx_i;
        if (special) mdu_res_o <= spec_res;
      end else if (state_q == CALC && state_d == DONE) begin
        mdu_res_o <= fin_res;
      end
    end
  end

  // Iteration datapath
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= ex_mdu_op_i;
      // Remainders follow the dividend's sign; everything else the XOR.
      neg_q <= (ex_mdu_op_i[2] && ex_mdu_op_i[1]) ? a_sgn : (a_sgn ^ b_sgn);
      opd_q <= ex_mdu_op_i[2] ? b_mag : a_mag;
      acc_q <= {{XLEN{1'b0}}, (ex_mdu_op_i[2] ? a_mag : b_mag)};
    end else if (state_q == CALC) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_k423_ex_mdu.sv
module tb_k423_ex_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        rdy;
  logic        flush = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rdi = '0;
  logic        mem_rdy = 1'b0;
  logic        res_vld;
  logic [31:0] res;
  logic [4:0]  res_rd;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  k423_ex_mdu #(.XLEN(32), .RIDX_W(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ex_stage_vld_i(vld), .ex_stage_rdy_o(rdy),
    .pcu_flush_br_i(flush), .ex_mdu_sel_i(sel), .ex_mdu_op_i(op),
    .ex_dec_rs1_i(rs1), .ex_dec_rs2_i(rs2), .ex_dec_rd_idx_i(rdi),
    .mem_stage_rdy_i(mem_rdy), .mdu_res_vld_o(res_vld), .mdu_res_o(res),
    .mdu_rd_idx_o(res_rd), .mdu_busy_o(busy)
  );

  // Reference model straight from the RV32M rules.
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: begin
        if (ua < 0) return 0;
        return (b == 0) ? a : a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one MDU op; report result, latency (0 = timeout) and the number of
  // cycles between accept and valid in which ready was seen high.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit hold,
                       output logic [31:0] r, output logic [4:0] rdo,
                       output int lat, output int rdy_hi);
    @(negedge clk);
    vld = 1'b1; sel = 1'b1; op = o; rs1 = a; rs2 = b; rdi = rd; mem_rdy = 1'b0;
    @(posedge clk);
    lat = 0; rdy_hi = 0; r = 'x; rdo = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vld = 1'b0; sel = 1'b0; rs1 = $urandom; rs2 = $urandom; rdi = 5'($urandom);
      end
      if (rdy) rdy_hi++;
      if (res_vld) begin
        lat = k; r = res; rdo = res_rd;
        break;
      end
    end
    if (lat != 0 && !hold) begin
      mem_rdy = 1'b1;
      @(negedge clk);
      mem_rdy = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", res_vld); end
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL reset_res got=%h exp=0", res); end
    checks++; if (res_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", res_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] t_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_r  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          t_l  [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] r;
    logic [4:0]  rdo;
    int lat, hi;
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 5'(i + 3), 1'b0, r, rdo, lat, hi);
      checks++; if (lat !== t_l[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, t_l[i]); end
      checks++; if (r !== t_r[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, t_r[i]); end
      checks++; if (rdo !== 5'(i + 3)) begin errors++; $display("FAIL dir%0d_rd got=%0d exp=%0d", i, rdo, i + 3); end
      checks++; if (hi !== 0) begin errors++; $display("FAIL dir%0d_ready_low got=%0d high cycles exp=0", i, hi); end
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b, r;
    logic [4:0]  rd, rdo;
    int lat, hi, mode;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; rd = 5'($urandom);
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      else if (mode == 3) b = -32'($urandom_range(1, 15));
      do_op(o, a, b, rd, 1'b0, r, rdo, lat, hi);
      checks++; if (lat !== ref_lat(o, a, b)) begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, o, lat, ref_lat(o, a, b)); end
      checks++; if (r !== ref_mdu(o, a, b)) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r, ref_mdu(o, a, b)); end
      checks++; if (rdo !== rd) begin errors++; $display("FAIL rnd%0d_rd got=%0d exp=%0d", i, rdo, rd); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    logic [4:0]  rdo;
    int lat, hi;
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1, r, rdo, lat, hi);
    checks++; if (lat !== 33) begin errors++; $display("FAIL bp_latency got=%0d exp=33", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (res_vld !== 1'b1 || res !== 32'hFFFF_FFFE || res_rd !== 5'd9 || rdy !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got vld=%b res=%h rd=%0d rdy=%b exp 1/fffffffe/9/0", k, res_vld, res, res_rd, rdy);
      end
    end
    mem_rdy = 1'b1;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_on_transfer got=%b exp=1", rdy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (res_vld !== 1'b0 || busy !== 1'b0 || rdy !== 1'b1) begin
        errors++; $display("FAIL bp_after%0d got vld=%b busy=%b rdy=%b exp 0/0/1", k, res_vld, busy, rdy);
      end
    end
    mem_rdy = 1'b0;
  endtask

  task automatic test_flush_calc;
    int seen = 0;
    @(negedge clk);
    vld = 1'b1; sel = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rdi = 5'd4; mem_rdy = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      vld = 1'b0; sel = 1'b0;
    end
    flush = 1'b1;  // counter is 10 during this cycle
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || res_vld !== 1'b0 || rdy !== 1'b1) begin
      errors++; $display("FAIL flush_calc got busy=%b vld=%b rdy=%b exp 0/0/1", busy, res_vld, rdy);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_vld) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_calc_no_result got=%0d valid cycles exp=0", seen); end
    // flush while idle blocks an MDU accept
    flush = 1'b1; vld = 1'b1; sel = 1'b1; op = 3'd0;
    @(negedge clk);
    flush = 1'b0; vld = 1'b0; sel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept got busy=%b exp=0", busy); end
    mem_rdy = 1'b0;
  endtask

  task automatic test_flush_done;
    logic [31:0] r;
    logic [4:0]  rdo;
    int lat, hi;
    do_op(3'd5, 32'd77, 32'd5, 5'd12, 1'b1, r, rdo, lat, hi);
    checks++; if (r !== 32'd15) begin errors++; $display("FAIL fd_result got=%h exp=f", r); end
    flush = 1'b1; mem_rdy = 1'b1;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL fd_rdy got=%b exp=0", rdy); end
    @(negedge clk);
    flush = 1'b0; mem_rdy = 1'b0;
    checks++; if (res_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fd_dropped got vld=%b busy=%b exp 0/0", res_vld, busy);
    end
  endtask

  task automatic test_reset_mid_calc;
    @(negedge clk);
    vld = 1'b1; sel = 1'b1; op = 3'd1; rs1 = 32'h1234_5678; rs2 = 32'h0ABC_DEF1; rdi = 5'd21;
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      vld = 1'b0; sel = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (res_vld !== 1'b0 || res !== 32'd0 || res_rd !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid got vld=%b res=%h rd=%0d busy=%b exp all 0", res_vld, res, res_rd, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_non_mdu;
    @(negedge clk);
    vld = 1'b1; sel = 1'b0; op = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rdy !== 1'b1 || busy !== 1'b0 || res_vld !== 1'b0) begin
        errors++; $display("FAIL non_mdu%0d got rdy=%b busy=%b vld=%b exp 1/0/0", k, rdy, busy, res_vld);
      end
    end
    vld = 1'b0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_non_mdu;
    test_flush_calc;
    test_flush_done;
    test_backpressure;
    test_reset_mid_calc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/k423_ex_mdu.md
Name: k423_ex_mdu

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It is the consuming end of the ID->EX valid/ready handshake: it drives EX-stage ready and holds the ID/EX register while an MDU instruction is computing. Results go to the EX->MEM side through a valid/ready pair. Non-MDU instructions pass with ready held high.

Parameters:
XLEN, 32, operand and result width (CORE_XLEN)
RIDX_W, 5, register index width (INST_RSDIDX_W)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
ex_stage_vld_i  in  1  ID->EX valid (id2ex_stage_vld)
ex_stage_rdy_o  out  1  EX ready back to the ID/EX pipe
pcu_flush_br_i  in  1  branch flush from PCU
ex_mdu_sel_i  in  1  instruction in EX is an MDU op (decoded group)
ex_mdu_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
ex_dec_rs1_i  in  XLEN  operand a
ex_dec_rs2_i  in  XLEN  operand b
ex_dec_rd_idx_i  in  RIDX_W  destination index
mem_stage_rdy_i  in  1  downstream ready
mdu_res_vld_o  out  1  result valid
mdu_res_o  out  XLEN  result
mdu_rd_idx_o  out  RIDX_W  destination of result
mdu_busy_o  out  1  state != IDLE

Behaviour:
- Reset (sync, rst_n_i low at posedge): state IDLE, counter 0, all output registers 0. Reset overrides every other event, including mid-CALC.
- States: IDLE, CALC, DONE.
- ex_stage_rdy_o = (IDLE) | (DONE & mem_stage_rdy_i & ~pcu_flush_br_i); combinational.
- Accept is (IDLE & ex_stage_vld_i & ex_mdu_sel_i & ~pcu_flush_br_i). On accept, latch op, rd_idx and operand magnitudes plus sign flags:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Special cases at accept go straight to DONE with the result registered:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow: DIV 0x80000000 / -1 gives 0x80000000; REM gives 0.
- CALC runs exactly 32 cycles, with a 5-bit counter 0..31.
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit product. Negate if the signs differ. MUL returns [31:0]; the others return [63:32].
  - Divide: restoring division on magnitudes. Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - At count 31, register the final result and enter DONE.
- Latency: accept in cycle T gives mdu_res_vld_o in cycle T+33; special cases give it in T+1.
- DONE: mdu_res_vld_o=1, with mdu_res_o and mdu_rd_idx_o stable. Transfer happens when mem_stage_rdy_i=1, then go to IDLE and drop valid. With no ready, hold indefinitely.
- No re-accept in the DONE->IDLE cycle: the ID/EX register loads the next instruction on that same edge.
- Flush: in CALC or DONE, go to IDLE on the next edge with valid 0; no result is delivered.
  - Flush wins over a same-cycle transfer.
  - Flush in IDLE blocks accept.
- ex_stage_rdy_o is low throughout CALC, and in DONE while mem_stage_rdy_i is low.
- Non-MDU valid instruction in IDLE: no state change, ready stays 1.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD: ready low T+1..T+33; valid at T+33 with result 0xFFFFFFEB, rd_idx echoed.
- Multiply high variants:
  - MULH 0x80000000*0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFF.
- Divide and remainder:
  - DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14; REMU 100/7 gives 2.
  - Each result valid at T+33.
- Special cases, each valid at T+1:
  - DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Backpressure: mem_stage_rdy_i low for 5 cycles in DONE gives stable result, valid=1, ex ready=0. Raising ready gives exactly one transfer, then IDLE and ready=1.
- Abort cases:
  - Flush at CALC count 10: IDLE next cycle, no valid, ready=1.
  - rst_n_i low mid-CALC: all outputs 0 after the edge.
  - Flush coincident with DONE & mem ready: no transfer.
